// File: rtl/push_btn_poller.sv
// Round-robin poller for four push-button devices: issues RBS reads, latches presses into
// pending bits and presents them to a consumer as an acknowledged event stream.
module push_btn_poller #(
  parameter int unsigned PollInterval = 1000,
  parameter int unsigned CounterSize  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [11:0] btn_inst,
  output logic [3:0]  btn_inst_en,
  input  logic [3:0]  btn_status,
  output logic [3:0]  pending,
  output logic        event_valid,
  output logic [1:0]  event_id,
  input  logic        event_ack,
  output logic        error
);

  localparam logic [2:0] StReset  = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StIssue  = 3'd2;
  localparam logic [2:0] StSample = 3'd3;
  localparam logic [2:0] StWait   = 3'd4;
  localparam logic [2:0] StError  = 3'd5;

  localparam logic [3:0] OpEn  = 4'd1;
  localparam logic [3:0] OpDis = 4'd2;
  localparam logic [3:0] OpClr = 4'd3;

  localparam logic [11:0] InstRbs = 12'h100;

  // Last Wait count; a zero interval still spends one cycle in Wait.
  localparam logic [CounterSize-1:0] CntLast =
      (PollInterval == 0) ? '0 : CounterSize'(PollInterval - 1);

  logic [2:0]             state_q, state_d;
  logic [3:0]             mask_q, mask_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [CounterSize-1:0] cnt_q, cnt_d;
  logic [3:0]             pending_q, pending_d;
  logic                   dis_q, dis_d;

  logic [3:0] opcode;
  logic       cmd_ok, is_en, is_dis, is_clr, is_bad;
  logic       issue_hit;
  logic       unused_inst;

  assign unused_inst = ^inst[7:4];

  assign opcode    = inst[11:8];
  assign cmd_ok    = inst_en && (state_q != StReset);
  assign is_en     = cmd_ok && (opcode == OpEn);
  assign is_dis    = cmd_ok && (opcode == OpDis);
  assign is_clr    = cmd_ok && (opcode == OpClr);
  assign is_bad    = cmd_ok && (opcode > OpClr);
  assign issue_hit = (state_q == StIssue) && mask_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    dis_d     = dis_q;

    if (is_en) begin
      mask_d = inst[3:0];
    end

    // Clears first, then the Sample set, so a press seen this cycle is never lost.
    if (is_clr) begin
      pending_d = '0;
    end
    if (event_ack && event_valid) begin
      pending_d[event_id] = 1'b0;
    end
    if (state_q == StSample) begin
      pending_d[ptr_q] = pending_d[ptr_q] | btn_status[ptr_q];
    end

    case (state_q)
      StReset: begin
        state_d = StIdle;
      end
      StIdle: begin
        dis_d = 1'b0;
        if (is_en && (inst[3:0] != 4'b0000)) begin
          ptr_d   = 2'd0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mask_q[ptr_q]) begin
          // An RBS is in flight; remember a DIS and honour it after the Sample.
          state_d = StSample;
          if (is_dis) begin
            dis_d = 1'b1;
          end
        end else if (is_dis) begin
          state_d = StIdle;
        end else if (ptr_q == 2'd3) begin
          ptr_d   = 2'd0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          ptr_d = ptr_q + 2'd1;
        end
      end
      StSample: begin
        if (is_dis || dis_q) begin
          dis_d   = 1'b0;
          state_d = StIdle;
        end else if (ptr_q == 2'd3) begin
          ptr_d   = 2'd0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          ptr_d   = ptr_q + 2'd1;
          state_d = StIssue;
        end
      end
      StWait: begin
        if (is_dis) begin
          state_d = StIdle;
        end else if (cnt_q >= CntLast) begin
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + CounterSize'(1);
        end
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StError;
      end
    endcase

    if (is_bad || (state_d == StError)) begin
      state_d   = StError;
      pending_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StReset;
      mask_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      dis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      dis_q     <= dis_d;
    end
  end

  always_comb begin
    btn_inst    = 12'h000;
    btn_inst_en = 4'b0000;
    if (issue_hit) begin
      btn_inst    = InstRbs;
      btn_inst_en = 4'b0001 << ptr_q;
    end
  end

  assign pending     = pending_q;
  assign event_valid = |pending_q;
  assign error       = (state_q == StError);

  always_comb begin
    event_id = 2'd0;
    if (pending_q[0]) begin
      event_id = 2'd0;
    end else if (pending_q[1]) begin
      event_id = 2'd1;
    end else if (pending_q[2]) begin
      event_id = 2'd2;
    end else if (pending_q[3]) begin
      event_id = 2'd3;
    end
  end

endmodule

// File: tb/tb_push_btn_poller.sv
// Self-checking bench for push_btn_poller: expected enable and event values are queued as
// stimulus is applied and popped against the DUT cycle by cycle.
module tb_push_btn_poller;

  localparam int unsigned PollIvl = 4;

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic [11:0] btn_inst;
  logic [3:0]  btn_inst_en;
  logic [3:0]  btn_status;
  logic [3:0]  pending;
  logic        event_valid;
  logic [1:0]  event_id;
  logic        event_ack;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [3:0] en_q[$];
  logic [6:0] ev_q[$];  // {event_valid, event_id, pending}

  push_btn_poller #(
    .PollInterval(PollIvl),
    .CounterSize (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .inst       (inst),
    .inst_en    (inst_en),
    .btn_inst   (btn_inst),
    .btn_inst_en(btn_inst_en),
    .btn_status (btn_status),
    .pending    (pending),
    .event_valid(event_valid),
    .event_id   (event_id),
    .event_ack  (event_ack),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [3:0] m);
    inst    = {op, 4'h0, m};
    inst_en = 1'b1;
    step();
    inst_en = 1'b0;
    inst    = 12'h000;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    inst_en    = 1'b0;
    inst       = 12'h000;
    event_ack  = 1'b0;
    btn_status = 4'b0000;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_en(input logic [3:0] v, input int budget);
    int n = 0;
    while (btn_inst_en !== v && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (btn_inst_en !== v) begin
      errors++;
      $display("FAIL wait_en: btn_inst_en=%b, required %b within %0d cycles",
               btn_inst_en, v, budget);
    end
  endtask

  task automatic pop_en(input string name);
    logic [3:0]  exp;
    logic [11:0] exp_inst;
    exp      = en_q.pop_front();
    exp_inst = (exp != 4'b0000) ? 12'h100 : 12'h000;
    checks++;
    if (btn_inst_en !== exp) begin
      errors++;
      $display("FAIL %s btn_inst_en: got %b, expected %b", name, btn_inst_en, exp);
    end
    checks++;
    if (btn_inst !== exp_inst) begin
      errors++;
      $display("FAIL %s btn_inst: got %h, expected %h", name, btn_inst, exp_inst);
    end
  endtask

  task automatic pop_ev(input string name);
    logic [6:0] exp;
    exp = ev_q.pop_front();
    checks++;
    if ({event_valid, event_id, pending} !== exp) begin
      errors++;
      $display("FAIL %s event: got valid=%b id=%0d pending=%b, expected valid=%b id=%0d pending=%b",
               name, event_valid, event_id, pending, exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    inst    = 12'h10F;
    inst_en = 1'b1;
    event_ack  = 1'b0;
    btn_status = 4'b1111;
    step();
    checks++;
    if ({btn_inst, btn_inst_en, pending, event_valid, event_id, error} !== 24'h0) begin
      errors++;
      $display("FAIL reset outputs: got inst=%h en=%b pend=%b v=%b id=%0d err=%b, expected all 0",
               btn_inst, btn_inst_en, pending, event_valid, event_id, error);
    end
    step();
    reset   = 1'b0;
    inst_en = 1'b0;
    step();
    step();
    checks++;
    if ({btn_inst_en, pending, error} !== 9'h0) begin
      errors++;
      $display("FAIL reset idle: got en=%b pend=%b err=%b, expected 0", btn_inst_en, pending,
               error);
    end
    btn_status = 4'b0000;
  endtask

  task automatic test_round_all();
    logic [3:0] seq [20] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0,
                             4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    reset_dut();
    for (int i = 0; i < 20; i++) en_q.push_back(seq[i]);
    do_cmd(4'h1, 4'hF);
    while (en_q.size() > 0) begin
      pop_en("round_all");
      step();
    end
  endtask

  task automatic test_sparse();
    logic [3:0] seq [14] = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                             4'h1, 4'h0, 4'h0, 4'h4};
    reset_dut();
    for (int i = 0; i < 14; i++) en_q.push_back(seq[i]);
    do_cmd(4'h1, 4'b0101);
    while (en_q.size() > 0) begin
      pop_en("sparse");
      step();
    end
  endtask

  task automatic test_pending();
    reset_dut();
    btn_status = 4'b0110;
    do_cmd(4'h1, 4'hF);
    for (int i = 0; i < 8; i++) step();
    btn_status = 4'b0000;
    ev_q.push_back({1'b1, 2'd1, 4'b0110});
    pop_ev("pending_first");
    event_ack = 1'b1;
    ev_q.push_back({1'b1, 2'd2, 4'b0100});
    step();
    event_ack = 1'b0;
    pop_ev("pending_ack1");
    event_ack = 1'b1;
    ev_q.push_back({1'b0, 2'd0, 4'b0000});
    step();
    event_ack = 1'b0;
    pop_ev("pending_ack2");
    event_ack = 1'b1;
    ev_q.push_back({1'b0, 2'd0, 4'b0000});
    step();
    event_ack = 1'b0;
    pop_ev("pending_idle_ack");
    // CLR clears pending without stopping the round.
    btn_status = 4'b1001;
    wait_en(4'b1000, 20);
    step();
    step();
    btn_status = 4'b0000;
    ev_q.push_back({1'b1, 2'd0, 4'b1001});
    pop_ev("pending_round2");
    ev_q.push_back({1'b0, 2'd0, 4'b0000});
    do_cmd(4'h3, 4'h0);
    pop_ev("pending_clr");
    wait_en(4'b0001, 20);
  endtask

  task automatic test_ack_collision();
    reset_dut();
    btn_status = 4'b0100;
    do_cmd(4'h1, 4'b0100);
    wait_en(4'b0100, 10);
    step();
    step();
    ev_q.push_back({1'b1, 2'd2, 4'b0100});
    pop_ev("collide_first");
    wait_en(4'b0100, 20);
    step();
    event_ack = 1'b1;
    ev_q.push_back({1'b1, 2'd2, 4'b0100});
    step();
    event_ack = 1'b0;
    pop_ev("collide_sample_wins");
    event_ack = 1'b1;
    ev_q.push_back({1'b0, 2'd0, 4'b0000});
    step();
    event_ack  = 1'b0;
    btn_status = 4'b0000;
    pop_ev("collide_plain_ack");
  endtask

  task automatic test_dis();
    reset_dut();
    do_cmd(4'h1, 4'hF);
    wait_en(4'b1000, 10);
    btn_status = 4'b1000;
    en_q.push_back(4'b0000);
    do_cmd(4'h2, 4'h0);
    pop_en("dis_sample");
    step();
    btn_status = 4'b0000;
    ev_q.push_back({1'b1, 2'd3, 4'b1000});
    pop_ev("dis_sampled");
    for (int i = 0; i < 12; i++) en_q.push_back(4'b0000);
    while (en_q.size() > 0) begin
      pop_en("dis_quiet");
      step();
    end
  endtask

  task automatic test_error();
    reset_dut();
    btn_status = 4'b1111;
    do_cmd(4'h1, 4'hF);
    wait_en(4'b1000, 10);
    step();
    step();
    btn_status = 4'b0000;
    do_cmd(4'h7, 4'h0);
    checks++;
    if ({error, btn_inst, btn_inst_en, pending, event_valid, event_id} !== 24'h800000) begin
      errors++;
      $display("FAIL error_entry: got err=%b inst=%h en=%b pend=%b v=%b id=%0d, expected err only",
               error, btn_inst, btn_inst_en, pending, event_valid, event_id);
    end
    btn_status = 4'b1111;
    do_cmd(4'h1, 4'hF);
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (error !== 1'b1 || btn_inst_en !== 4'b0000 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL error_sticky: got err=%b en=%b pend=%b, expected 1/0000/0000",
               error, btn_inst_en, pending);
    end
    reset_dut();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared: got err=%b, expected 0", error);
    end
    en_q.push_back(4'b0001);
    do_cmd(4'h1, 4'b0001);
    pop_en("error_recover");
  endtask

  initial begin
    reset      = 1'b1;
    inst       = 12'h000;
    inst_en    = 1'b0;
    btn_status = 4'b0000;
    event_ack  = 1'b0;
    test_reset();
    test_round_all();
    test_sparse();
    test_pending();
    test_ack_collision();
    test_dis();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_btn_poller.md
PUSH_BTN_POLLER -- requirements
Module: push_btn_poller

Interface
REQ-001 Parameter PollInterval, default 1000, idle cycles between the end of one poll round and the start of the next.
REQ-002 Parameter CounterSize, default 16, width of the interval counter; PollInterval SHALL be below 2^CounterSize.
REQ-003 clock  input  1  clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 inst  input  12  command word; opcode inst[11:8], device mask inst[3:0].
REQ-006 inst_en  input  1  inst valid this cycle.
REQ-007 btn_inst  output  12  shared instruction word driven to four push-button devices.
REQ-008 btn_inst_en  output  4  per-device instruction enable, at most one bit high.
REQ-009 btn_status  input  4  per-device button_status returns.
REQ-010 pending  output  4  latched unacknowledged presses, one bit per device.
REQ-011 event_valid  output  1  high while pending is nonzero.
REQ-012 event_id  output  2  index of the lowest set pending bit; 0 when pending is zero.
REQ-013 event_ack  input  1  consumer acknowledge of event_id.
REQ-014 error  output  1  high in Error state.

Function
REQ-015 Opcodes SHALL be: 0 NOP; 1 EN (load mask from inst[3:0], start polling); 2 DIS (stop polling); 3 CLR (clear pending). Any other opcode with inst_en high, in any state except Reset, SHALL move the block to Error.
REQ-016 States SHALL be Reset, Idle, Issue, Sample, Wait, Error. Reset goes to Idle unconditionally after one cycle.
REQ-017 Idle: on EN with a nonzero mask, set ptr=0 and go to Issue. EN with a zero mask SHALL load the mask and stay in Idle.
REQ-018 Issue, mask[ptr]=1: drive btn_inst=12'h100 (RBS) and btn_inst_en=onehot(ptr) for exactly one cycle, then go to Sample.
REQ-019 Issue, mask[ptr]=0: skip the device; drive no enable and advance ptr within the same cycle. Each skipped device SHALL cost exactly one cycle.
REQ-020 Sample: btn_inst=0 and btn_inst_en=0; set pending[ptr] |= btn_status[ptr]; then advance ptr.
REQ-021 Advance: if ptr<3, ptr+1 and go to Issue; if ptr==3, ptr wraps to 0, clear the counter and go to Wait.
REQ-022 Wait: count clock cycles; after PollInterval cycles, go to Issue. A round with all four devices enabled SHALL take 8 cycles plus PollInterval.
REQ-023 DIS in Idle, Issue or Wait SHALL go to Idle next cycle. DIS received in Issue with an enable already driven SHALL first complete that device's Sample, then go to Idle. An RBS SHALL never be left unsampled.
REQ-024 EN while polling SHALL update the mask; the new mask applies from the next Issue decision and ptr is not changed.
REQ-025 Outside Issue, btn_inst SHALL be 12'h000 and btn_inst_en SHALL be 4'b0000.
REQ-026 Ack: event_ack with event_valid clears pending[event_id] at the next edge. event_ack while event_valid is low SHALL be ignored.
REQ-027 CLR SHALL clear all pending bits; polling state is unaffected.
REQ-028 Same-cycle priority per bit: a Sample set wins over an ack clear and over a CLR clear, so no press is lost.
REQ-029 event_valid, event_id and error SHALL be combinational from registered state.
REQ-030 Error: all outputs are 0 except error=1. The state is sticky until reset.

Reset
REQ-031 While reset is high at a clock edge, the next state SHALL be Reset, with mask=0, pending=0, ptr=0 and counter=0.
REQ-032 In the Reset state, btn_inst=0, btn_inst_en=0, pending=0, event_valid=0, event_id=0 and error=0.
REQ-033 Reset mid-round SHALL abort without completing a Sample; inst is ignored during reset.

Verification
REQ-034 Bench SHALL cover: reset, then EN mask=4'hF, PollInterval=4 -> btn_inst_en sequence 0001,0,0010,0,0100,0,1000,0, then 4 idle cycles, then repeat.
REQ-035 Bench SHALL cover: EN mask=4'b0101 -> enables 0001 and 0100 only, each followed by a Sample cycle; devices 1 and 3 cost one cycle each.
REQ-036 Bench SHALL cover: btn_status[2]=1 and btn_status[1]=1 during the respective Samples -> pending=0110, event_id=1; ack gives pending=0100, event_id=2; ack gives event_valid=0.
REQ-037 Bench SHALL cover: ack of id 2 in the same cycle as a Sample of device 2 with status=1 -> pending[2] remains 1.
REQ-038 Bench SHALL cover: DIS in the cycle device 3's enable is driven -> Sample completes, then Idle, with no further enables.
REQ-039 Bench SHALL cover: opcode 4'h7 with inst_en while in Wait -> error=1 and all enables 0; stays until reset, after which Idle is reached with error=0.
